// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared element and skew-line entry types for the input skew buffer
package router_pkg;

    localparam int DEFAULT_ROW_COUNT = 4;
    localparam int ELEM_WIDTH        = 8;

    typedef logic [ELEM_WIDTH-1:0] elem_t;

    typedef struct packed {
        logic  valid;
        elem_t data;
    } skew_entry_t;

endpackage

// File: rtl/row_fifo.sv
// rtl/row_fifo.sv - per-row synchronous FIFO with head word available combinationally
module row_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  elem_t         wdata,
    output elem_t         rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    elem_t          mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a word when its head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/input_skew_buffer.sv
// rtl/input_skew_buffer.sv - per-row FIFOs feeding diagonal-skewed columns into the PE array west edge
module input_skew_buffer
    import router_pkg::*;
#(
    parameter int ROW_COUNT  = DEFAULT_ROW_COUNT,
    parameter int DATA_WIDTH = ELEM_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            i_clk,
    input  logic                            i_nrst,
    input  logic                            i_en,
    input  logic                            i_reg_clear,
    input  logic [ROW_COUNT*DATA_WIDTH-1:0] i_data,
    input  logic [ROW_COUNT-1:0]            i_data_valid,
    output logic                            o_pop_en,
    input  logic                            i_stall,
    input  logic                            i_drain,
    output logic [ROW_COUNT*DATA_WIDTH-1:0] o_data,
    output logic [ROW_COUNT-1:0]            o_data_valid,
    output logic                            o_empty,
    output logic                            o_overflow,
    output logic [CNT_WIDTH-1:0]            o_issue_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    elem_t                head        [ROW_COUNT];
    logic [CW-1:0]        fifo_count  [ROW_COUNT];
    skew_entry_t          issue_entry [ROW_COUNT];
    skew_entry_t          lane_in     [ROW_COUNT];
    skew_entry_t          out_q       [ROW_COUNT];
    logic [ROW_COUNT-1:0] fifo_full;
    logic [ROW_COUNT-1:0] fifo_empty;
    logic [ROW_COUNT-1:0] pop;
    logic [ROW_COUNT-1:0] push_ok;
    logic [ROW_COUNT-1:0] line_busy;
    logic                 issue;
    logic                 overflow_set;
    logic                 pop_en_nxt;
    logic                 empty_nxt;
    logic                 busy_nxt;
    logic [CW-1:0]        cnt_nxt;

    assign issue = i_en & ~i_stall &
                   ((&(~fifo_empty)) | (i_drain & (|(~fifo_empty))));
    assign overflow_set = |(i_data_valid & fifo_full & ~pop);

    for (genvar r = 0; r < ROW_COUNT; r++) begin : g_row
        row_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (i_clk),
            .rst_n (i_nrst),
            .clear (i_reg_clear),
            .push  (i_data_valid[r]),
            .pop   (pop[r]),
            .wdata (i_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .rdata (head[r]),
            .full  (fifo_full[r]),
            .empty (fifo_empty[r]),
            .count (fifo_count[r])
        );

        assign pop[r]         = issue & ~fifo_empty[r];
        assign push_ok[r]     = i_data_valid[r] & (~fifo_full[r] | pop[r]);
        assign issue_entry[r] = '{valid: pop[r], data: (pop[r] ? head[r] : '0)};
        assign o_data[r*DATA_WIDTH +: DATA_WIDTH] = out_q[r].data;
        assign o_data_valid[r]                    = out_q[r].valid;

        if (r == 0) begin : g_direct
            assign lane_in[r]   = issue_entry[r];
            assign line_busy[r] = 1'b0;
        end else begin : g_line
            // Row r waits r extra beats so the array sees a diagonal wavefront.
            skew_entry_t line_q [r];
            logic        busy;

            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    for (int k = 0; k < r; k++) line_q[k] <= '0;
                end else if (i_reg_clear) begin
                    for (int k = 0; k < r; k++) line_q[k] <= '0;
                end else if (!i_stall) begin
                    line_q[0] <= issue_entry[r];
                    for (int k = 1; k < r; k++) line_q[k] <= line_q[k-1];
                end
            end

            always_comb begin
                busy = 1'b0;
                for (int k = 0; k < r; k++) busy = busy | line_q[k].valid;
            end

            assign lane_in[r]   = line_q[r-1];
            assign line_busy[r] = busy;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int r = 0; r < ROW_COUNT; r++) out_q[r] <= '0;
        end else if (i_reg_clear) begin
            for (int r = 0; r < ROW_COUNT; r++) out_q[r] <= '0;
        end else if (!i_stall) begin
            for (int r = 0; r < ROW_COUNT; r++) out_q[r] <= lane_in[r];
        end
    end

    // Status flags look at next-cycle occupancy so one in-flight router word always fits.
    always_comb begin
        pop_en_nxt = i_en;
        empty_nxt  = 1'b1;
        busy_nxt   = 1'b0;
        cnt_nxt    = '0;
        for (int r = 0; r < ROW_COUNT; r++) begin
            cnt_nxt  = fifo_count[r] + CW'(push_ok[r]) - CW'(pop[r]);
            busy_nxt = i_stall ? (line_busy[r] | out_q[r].valid)
                               : (issue_entry[r].valid | line_busy[r]);
            if (cnt_nxt > CW'(FIFO_DEPTH - 2)) pop_en_nxt = 1'b0;
            if ((cnt_nxt != '0) || busy_nxt)   empty_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_pop_en      <= 1'b0;
            o_empty       <= 1'b1;
            o_overflow    <= 1'b0;
            o_issue_count <= '0;
        end else if (i_reg_clear) begin
            o_pop_en      <= 1'b0;
            o_empty       <= 1'b1;
            o_overflow    <= 1'b0;
            o_issue_count <= '0;
        end else begin
            o_pop_en <= pop_en_nxt;
            o_empty  <= empty_nxt;
            if (overflow_set) o_overflow    <= 1'b1;
            if (issue)        o_issue_count <= o_issue_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_input_skew_buffer.sv
// tb/tb_input_skew_buffer.sv - self-checking bench for input_skew_buffer
module tb_input_skew_buffer;

    localparam int R = 4;
    localparam int D = 4;

    logic        clk   = 1'b0;
    logic        nrst  = 1'b0;
    logic        en    = 1'b0;
    logic        clear = 1'b0;
    logic        stall = 1'b0;
    logic        drain = 1'b0;
    logic [3:0]  dv    = 4'h0;
    logic [31:0] din   = 32'h0;
    logic        pop_en;
    logic [31:0] dout;
    logic [3:0]  dvout;
    logic        empty;
    logic        ovf;
    logic [15:0] icnt;

    always #5 clk = ~clk;

    input_skew_buffer dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_en          (en),
        .i_reg_clear   (clear),
        .i_data        (din),
        .i_data_valid  (dv),
        .o_pop_en      (pop_en),
        .i_stall       (stall),
        .i_drain       (drain),
        .o_data        (dout),
        .o_data_valid  (dvout),
        .o_empty       (empty),
        .o_overflow    (ovf),
        .o_issue_count (icnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word queues per row, plus a history of issued columns
    // indexed by non-stalled cycles; row r shows the column issued r+1 advances ago.
    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
    } col_t;

    logic [7:0]  mq [R][$];
    col_t        hist[$];
    logic        m_pop;
    logic        m_ovf;
    logic [15:0] m_cnt;

    task automatic model_reset();
        for (int r = 0; r < R; r++) mq[r].delete();
        hist.delete();
        m_pop = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 16'd0;
    endtask

    task automatic model_step();
        col_t c;
        bit   any_ne;
        bit   all_ne;
        if (!nrst || clear) begin
            model_reset();
            return;
        end
        c.v = 4'h0;
        c.d = 32'h0;
        any_ne = 1'b0;
        all_ne = 1'b1;
        for (int r = 0; r < R; r++) begin
            if (mq[r].size() > 0) any_ne = 1'b1;
            else                  all_ne = 1'b0;
        end
        if (en && !stall && (all_ne || (drain && any_ne))) begin
            for (int r = 0; r < R; r++) begin
                if (mq[r].size() > 0) begin
                    c.v[r]       = 1'b1;
                    c.d[8*r +: 8] = mq[r].pop_front();
                end
            end
            m_cnt++;
        end
        for (int r = 0; r < R; r++) begin
            if (dv[r]) begin
                if (mq[r].size() < D) mq[r].push_back(din[8*r +: 8]);
                else                  m_ovf = 1'b1;
            end
        end
        if (!stall) begin
            hist.push_back(c);
            if (hist.size() > R + 1) void'(hist.pop_front());
        end
        m_pop = en;
        for (int r = 0; r < R; r++) if (mq[r].size() > D - 2) m_pop = 1'b0;
    endtask

    task automatic check_all(string tag);
        logic [31:0] ed;
        logic [3:0]  ev;
        logic        ee;
        col_t        e;
        ed = 32'h0;
        ev = 4'h0;
        ee = 1'b1;
        for (int r = 0; r < R; r++) begin
            if (mq[r].size() != 0) ee = 1'b0;
            for (int j = 0; j <= r; j++) begin
                if (hist.size() > j) begin
                    e = hist[hist.size() - 1 - j];
                    if (e.v[r]) ee = 1'b0;
                    if (j == r) begin
                        ev[r]         = e.v[r];
                        ed[8*r +: 8]  = e.d[8*r +: 8];
                    end
                end
            end
        end
        chk({tag, " data"},     dout,   ed);
        chk({tag, " valid"},    dvout,  32'(ev));
        chk({tag, " pop_en"},   pop_en, 32'(m_pop));
        chk({tag, " empty"},    empty,  32'(ee));
        chk({tag, " overflow"}, ovf,    32'(m_ovf));
        chk({tag, " count"},    icnt,   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        en;
        logic        stall;
        logic        drain;
        logic [3:0]  dv;
        logic [31:0] din;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [15:0] ecnt;
        logic        eempty;
        logic        epop;
    } vec_t;

    vec_t tbl [10];
    logic prev_pop;

    initial begin
        model_reset();
        tick();
        chk("reset valid",    dvout,  0);
        chk("reset data",     dout,   0);
        chk("reset pop_en",   pop_en, 0);
        chk("reset empty",    empty,  1);
        chk("reset overflow", ovf,    0);
        chk("reset count",    icnt,   0);
        nrst = 1'b1;

        // Single-column skew timing, then a partial-column drain.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h44332211, 4'h0, 32'h00000000, 16'd0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h1, 32'h00000011, 16'd1, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h2, 32'h00002200, 16'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h4, 32'h00330000, 16'd1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h8, 32'h44000000, 16'd1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h0, 32'h00000000, 16'd1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 4'h3, 32'h0000B1A0, 4'h0, 32'h00000000, 16'd1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 4'h0, 32'h0,        4'h1, 32'h000000A0, 16'd2, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h2, 32'h0000B100, 16'd2, 1'b0, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h0,        4'h0, 32'h00000000, 16'd2, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            en    = tbl[i].en;
            stall = tbl[i].stall;
            drain = tbl[i].drain;
            dv    = tbl[i].dv;
            din   = tbl[i].din;
            tick();
            chk($sformatf("vec%0d valid", i),  dvout,  32'(tbl[i].ev));
            chk($sformatf("vec%0d data", i),   dout,   tbl[i].ed);
            chk($sformatf("vec%0d count", i),  icnt,   32'(tbl[i].ecnt));
            chk($sformatf("vec%0d empty", i),  empty,  32'(tbl[i].eempty));
            chk($sformatf("vec%0d pop_en", i), pop_en, 32'(tbl[i].epop));
        end
        drain = 1'b0;

        // Asynchronous reset mid-stream with data in flight and FIFOs half full.
        dv = 4'hF; din = 32'h04030201; tick();
        din = 32'h08070605; tick();
        stall = 1'b1; din = 32'h0C0B0A09; tick();
        chk("pre-reset lane0 valid", dvout[0], 1);
        dv = 4'h0;
        nrst = 1'b0;
        #1;
        chk("async reset valid",  dvout,  0);
        chk("async reset pop_en", pop_en, 0);
        chk("async reset empty",  empty,  1);
        chk("async reset count",  icnt,   0);
        model_reset();
        tick();
        tick();
        nrst = 1'b1;
        stall = 1'b0;

        // Backpressure: stalled array while a router answers every pop request.
        dv = 4'hF; din = 32'h04030201; tick();
        dv = 4'h0; tick();
        stall = 1'b1;
        prev_pop = 1'b0;
        for (int i = 0; i < 12; i++) begin
            dv = prev_pop ? 4'hF : 4'h0;
            din = $urandom;
            prev_pop = pop_en;
            tick();
            chk("stall frozen data",  dout,  32'h00000001);
            chk("stall frozen valid", dvout, 1);
            check_all("backpressure");
        end
        chk("backpressure overflow", ovf,    0);
        chk("backpressure pop_en",   pop_en, 0);

        // Overflow: five pushes into row 2 with the array stalled.
        dv = 4'h0; clear = 1'b1; tick();
        clear = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dv  = 4'b0100;
            din = 32'(k + 1) << 16;
            tick();
            if (k == 3) chk("overflow before fifth", ovf, 0);
            check_all("overflow");
        end
        chk("overflow after fifth", ovf, 1);
        dv = 4'h0; tick(); tick();
        chk("overflow sticky", ovf, 1);
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("overflow cleared", ovf, 0);

        // Full FIFOs: pop and push in the same cycle keep every word in order.
        for (int k = 0; k < 4; k++) begin
            dv = 4'hF;
            for (int r = 0; r < R; r++) din[8*r +: 8] = 8'(16*k + r);
            tick();
        end
        stall = 1'b0;
        dv = 4'hF; din = 32'h43424140; tick();
        chk("full push+pop overflow", ovf, 0);
        chk("full push+pop lane0", dout[7:0], 8'h00);
        dv = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("full order lane0 #%0d", k), dout[7:0], 32'(16*k));
            chk($sformatf("full order valid0 #%0d", k), dvout[0], 1);
            check_all("full");
        end
        chk("full no overflow", ovf, 0);

        // Randomised run against the model.
        prev_pop = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom % 8) != 0;
            stall = ($urandom % 4) == 0;
            drain = ($urandom % 4) == 0;
            clear = ($urandom % 200) == 0;
            dv    = prev_pop ? 4'($urandom) : ((($urandom % 8) == 0) ? 4'($urandom) : 4'h0);
            din   = $urandom;
            prev_pop = pop_en;
            tick();
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_skew_buffer.md
Name: input_skew_buffer

Overview:
- Downstream stage of the input router; feeds the systolic PE array's west edge.
- Absorbs per-row router words into per-row FIFOs and generates the router's pop request from FIFO space.
- Issues one column at a time and skews row r by r cycles, so the array sees diagonal wavefronts.
- Honours a global array stall.

Parameters:
ROW_COUNT, 4, number of array rows (equals router count)
DATA_WIDTH, 8, element width
FIFO_DEPTH, 4, per-row FIFO entries, power of two, >= 2
CNT_WIDTH, 16, width of issued-column counter

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_en  in  1  block enable; gates o_pop_en and issue
i_reg_clear  in  1  synchronous clear of all state
i_data  in  ROW_COUNT x DATA_WIDTH  router output words
i_data_valid  in  ROW_COUNT  per-row valid from router
o_pop_en  out  1  pop request to router (drives router i_pop_en)
i_stall  in  1  array stall; freezes issue and skew lines
i_drain  in  1  issue partial columns (end of tile)
o_data  out  ROW_COUNT x DATA_WIDTH  skewed data to array
o_data_valid  out  ROW_COUNT  per-row valid to array
o_empty  out  1  all FIFOs and skew lines empty
o_overflow  out  1  sticky: push to a full FIFO occurred
o_issue_count  out  CNT_WIDTH  columns issued since clear

Behaviour:
- Reset (async, i_nrst=0):
  - FIFOs, pointers and skew lines are cleared.
  - o_pop_en=0, o_data=0, o_data_valid=0, o_overflow=0, o_issue_count=0, o_empty=1.
- i_reg_clear: same clearing, synchronous. It has priority over push, issue and stall in that cycle.
- Push:
  - Each cycle, row r pushes i_data[r] when i_data_valid[r]=1.
  - If FIFO r is full and is not popped this cycle, the word is dropped and o_overflow sets (sticky until reset or clear).
  - Push and pop on a full FIFO in the same cycle are legal; the count is unchanged.
- Pop request:
  - o_pop_en is registered.
  - It is 1 when i_en=1 and every FIFO has count <= FIFO_DEPTH-2. This leaves room for one in-flight router word.
- Issue decision (combinational):
  - issue = i_en & ~i_stall & (all FIFOs non-empty | (i_drain & any FIFO non-empty)).
  - On issue, every non-empty FIFO pops its head.
  - Rows that are empty under drain contribute valid=0 and data=0.
  - o_issue_count increments by 1 and wraps at 2^CNT_WIDTH.
- Skew:
  - Row r has a delay line of r registers, each holding {valid, data}. Row 0 has no delay line.
  - Every output lane has one output register.
  - Row r data issued in cycle t appears on o_data[r]/o_data_valid[r] in cycle t+1+r.
- Stall:
  - i_stall=1 holds all skew registers and output registers; o_data/o_data_valid keep their values.
  - FIFO pushes continue during stall; o_pop_en follows occupancy.
- Bubbles:
  - When not stalled and not issuing, a bubble (valid=0, data=0) enters row 0's output and the head of each delay line.
  - The lines shift normally, so in-flight data keeps draining.
- o_empty: registered. It is 1 when all FIFO counts are 0 and all skew-line/output valids are 0.
- i_en=0: no issue and o_pop_en=0; skew lines still shift unless stalled.
- Widths: FIFO count is $clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package router_pkg:
  - typedef elem_t = logic [DATA_WIDTH-1:0].
  - typedef skew_entry_t = struct {valid, elem_t data}.
  - Constant DEFAULT_ROW_COUNT.
- Sub-module row_fifo, instantiated ROW_COUNT times via generate:
  - Ports: push, pop, data in/out, full, empty, count.
  - Synchronous, with first-word data available combinationally at the head.
- Skew lines and issue logic stay in the top.

Test Plan:
- Reset/clear: pulse i_nrst low mid-stream with FIFOs half full -> o_data_valid=0000, o_pop_en=0, o_empty=1, o_issue_count=0 in the same cycle, without waiting for a clock edge.
- Skew timing: push one column {0x11,0x22,0x33,0x44} in cycle t with i_en=1 and no stall.
  - Issue occurs in cycle t+1.
  - o_data[0]=0x11 at t+2, o_data[1]=0x22 at t+3, o_data[2]=0x33 at t+4, o_data[3]=0x44 at t+5.
  - Each valid is high for exactly one cycle.
- Backpressure: hold i_stall=1 while pushing every cycle the router is popped.
  - o_pop_en drops once any count reaches 3 (DEPTH=4).
  - No overflow.
  - o_data stays frozen during the stall.
- Drain partial: rows 0 and 1 hold 0xA0 and 0xB1, rows 2 and 3 are empty, i_drain=1.
  - One issue occurs and o_issue_count becomes 1.
  - Rows 0 and 1 emit the data; rows 2 and 3 show valid=0.
  - o_empty=1 after all lanes drain.
- Overflow: force 5 pushes into row 2 with i_stall=1 and i_data_valid asserted directly.
  - The fifth word is dropped and o_overflow=1 stays set.
  - After i_reg_clear, o_overflow=0.
- Full push+pop: row FIFOs full, i_stall deasserted while a valid push arrives.
  - Count stays at 4, no overflow.
  - Data order is preserved: FIFO head outputs in push order.
